ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
AHB-Lite responder that fronts a word-organised on-chip SRAM. It decodes address and control phases, inserts a parameterised number of wait states, and performs byte/halfword/word writes and reads. It flags illegal accesses with a two-cycle ERROR response. Its outputs Hrdata_S, Hresp_S and Hreadyout_S feed one slot of the slave-to-master return mux.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, address bus width.
MEM_DEPTH, 256, number of 32-bit words; legal byte address range is 0 to 4*MEM_DEPTH-1.
WAIT_STATES, 1, wait cycles (Hreadyout=0) inserted before an OKAY completion; range 0 to 15.

Ports:
Hclk  input  1  bus clock; all state updates on the rising edge
Hresetn  input  1  reset, asynchronous, active-high
Hsel  input  1  slave select from the address decoder
Haddr  input  ADDR_WIDTH  transfer byte address
Htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
Hwrite  input  1  1 = write, 0 = read
Hsize  input  3  000 byte, 001 halfword, 010 word; others are illegal
Hwdata  input  DATA_WIDTH  write data, valid in the data phase
Hready  input  1  bus-level ready returned from the mux
Hrdata_S  output  DATA_WIDTH  read data
Hresp_S  output  2  00 OKAY, 01 ERROR
Hreadyout_S  output  1  slave ready / data-phase completion

Behaviour:
- Reset: Hresetn=1 forces these values immediately, without waiting for a clock edge: Hreadyout_S=1, Hresp_S=00, Hrdata_S=0, FSM=IDLE, wait counter=0, pending write discarded. SRAM contents are not cleared.
- Address phase accept: on a rising edge with Hsel=1, Hready=1 and Htrans[1]=1. When accepted, latch Haddr, Hwrite and Hsize. Otherwise no transfer starts.
- IDLE/BUSY with Hsel=1 and Hready=1: zero-wait OKAY, no memory access.
- Legality check at accept. A transfer is an error if any of these holds:
  - word index Haddr[ADDR_WIDTH-1:2] >= MEM_DEPTH;
  - Hsize > 010;
  - halfword access with Haddr[0]=1;
  - word access with Haddr[1:0]!=00.
- FSM states and transitions:
  - IDLE: Hreadyout_S=1, Hresp_S=00. On a legal accept, go to WAIT if WAIT_STATES>0, else to DONE. On an illegal accept, go to ERR1.
  - WAIT: Hreadyout_S=0, Hresp_S=00. Counter counts down from WAIT_STATES; go to DONE after WAIT_STATES cycles in WAIT.
  - DONE: Hreadyout_S=1, Hresp_S=00. Final data-phase cycle. Reads drive Hrdata_S; writes sample Hwdata and commit at the end of this cycle. A new accept in this cycle pipelines directly into the next transfer (WAIT, DONE or ERR1); otherwise go to IDLE.
  - ERR1: Hreadyout_S=0, Hresp_S=01; go to ERR2.
  - ERR2: Hreadyout_S=1, Hresp_S=01. No memory access. A new accept in this cycle is honoured; otherwise go to IDLE.
- Byte lanes are little-endian.
  - Byte write updates lane Haddr[1:0]; halfword write updates lanes {Haddr[1],0} and {Haddr[1],1}; word write updates all four lanes.
  - Reads always return the full 32-bit word at the latched word index.
- Hrdata_S is valid only in DONE of a read. It holds its last value otherwise; verification must not check it outside that cycle.
- Read-after-write: a read must return data including a write that commits on the same edge as the read's DONE. Forward from the write path when the word indices match, merging only the written lanes.
- Hsel falling during WAIT or ERR1 does not abort the transfer already in its data phase.
- With Hready=0 (another slave stalling), address phases are ignored and no state changes while the FSM is in IDLE.
- Reset asserted mid-transfer: abort immediately. No partial write is committed and the FSM returns to IDLE.

Test Plan:
1. Assert Hresetn=1 mid-run -> Hreadyout_S=1, Hresp_S=00, Hrdata_S=0 with no clock edge. After release, a read of 0x10 returns the value written before reset.
2. WAIT_STATES=1: word write 0xCAFEF00D to 0x10, then word read 0x10 -> each data phase shows exactly one Hreadyout_S=0 cycle, then Hreadyout_S=1, Hresp_S=00, Hrdata_S=0xCAFEF00D.
3. Byte write to 0x11 with Hwdata=0x0000AB00, then halfword write to 0x12 with Hwdata=0x12340000, then word read 0x10 -> Hrdata_S=0x1234AB0D.
4. Word read at 0x400 (index 256) and word write at 0x12 (misaligned) -> for each: one cycle Hreadyout_S=0/Hresp_S=01, one cycle Hreadyout_S=1/Hresp_S=01. Memory at 0x10 is unchanged.
5. WAIT_STATES=0: back-to-back NONSEQ write 0x55AA55AA to 0x20, then read 0x20 on the next cycle -> Hrdata_S=0x55AA55AA in the read's DONE cycle (forwarding), Hreadyout_S=1 every cycle.
6. Hsel=1 with Htrans=00, and separately Htrans=10 with Hready=0 -> no state change, Hreadyout_S=1, Hresp_S=00, and a later read shows the memory untouched.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder for a word-organised SRAM with wait states, byte lanes and ERROR responses
module ahb_sram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready,
    output logic [DATA_WIDTH-1:0] Hrdata_S,
    output logic [1:0]            Hresp_S,
    output logic                  Hreadyout_S
);
    localparam int IW = $clog2(MEM_DEPTH);
    typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0] lane_q, lane_d;
    logic [2:0] size_q, size_d;
    logic write_q, write_d;
    logic [3:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q, hold_q, fwd;
    logic [3:0] be;
    logic take, illegal, we, rd_done, unused_ok;
    assign unused_ok = Htrans[0];
    assign take = Hsel & Hready & Htrans[1] & (state_q inside {IDLE, DONE, ERR2});
    assign illegal = (Haddr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_DEPTH)) | (Hsize > 3'b010)
                   | (Hsize == 3'b001 & Haddr[0]) | (Hsize == 3'b010 & |Haddr[1:0]);
    assign be = size_q == 3'b000 ? 4'b0001 << lane_q : size_q == 3'b001 ? (lane_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign we = state_q == DONE & write_q;
    assign rd_done = state_q == DONE & !write_q;
    assign Hreadyout_S = !(state_q inside {WAIT, ERR1});
    assign Hresp_S = state_q inside {ERR1, ERR2} ? 2'b01 : 2'b00;
    assign Hrdata_S = rd_done ? rd_q : hold_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        idx_d = take ? Haddr[IW+1:2] : idx_q;
        lane_d = take ? Haddr[1:0] : lane_q;
        size_d = take ? Hsize : size_q;
        write_d = take ? Hwrite : write_q;
        unique case (state_q)
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? DONE : WAIT;
            end
            ERR1: state_d = ERR2;
            default: begin
                cnt_d = take ? 4'(WAIT_STATES) : cnt_q;
                state_d = !take ? IDLE : illegal ? ERR1 : WAIT_STATES > 0 ? WAIT : DONE;
            end
        endcase
    end
    // The SRAM read port is registered, so a write committing on the same edge is merged in by lane
    always_comb begin
        fwd = mem[idx_d];
        for (int b = 0; b < 4; b++)
            if (we && be[b] && idx_q == idx_d) fwd[8*b+:8] = Hwdata[8*b+:8];
    end
    always_ff @(posedge Hclk) begin
        if (we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx_q][8*b+:8] <= Hwdata[8*b+:8];
        rd_q <= fwd;
    end
    always_ff @(posedge Hclk or posedge Hresetn) begin
        if (Hresetn) begin
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            lane_q <= '0;
            size_q <= '0;
            write_q <= 1'b0;
            hold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            lane_q <= lane_d;
            size_q <= size_d;
            write_q <= write_d;
            hold_q <= Hrdata_S;
        end
    end
endmodule
